// File: rtl/iter_shifter_pkg.sv
// Shared constants for the iterative shifter: shift mode codes and FSM state encoding.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/iter_shifter_if.sv
// Request/response bundle for the iterative shifter; the execute stage is the master.
interface iter_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic [1:0]         mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic               busy;

  modport master (
    output in_valid, data_in, shamt, mode, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, data_in, shamt, mode, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/iter_shifter_shift_step.sv
// One combinational sub-step: shifts data by k (0..STEP) bits in the selected mode.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result
);
  // Wide enough to hold WIDTH itself, so the rotate's left shift by WIDTH-0 yields zero.
  localparam int SW = $clog2(WIDTH) + 1;

  logic [SW-1:0] k_w;
  logic [SW-1:0] lsh;

  // Select the shifted operand for the current mode.
  always_comb begin
    k_w    = SW'(k);
    lsh    = SW'(WIDTH) - k_w;
    result = data;
    case (mode)
      MODE_SLL: result = data << k_w;
      MODE_SRL: result = data >> k_w;
      MODE_SRA: result = $unsigned($signed(data) >>> k_w);
      MODE_ROR: result = (data >> k_w) | (data << lsh);
      default:  result = data;
    endcase
  end
endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: consumes up to STEP bits of shift amount per clock.
//
//   state    | meaning
//   ST_IDLE  | ready for a request, operand latched on in_valid
//   ST_SHIFT | shifting acc by min(STEP, rem) each edge
//   ST_DONE  | result presented, waiting for out_ready
module iter_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic    clock,
  input  logic    reset_n,
  iter_shifter_if.slave bus
);
  localparam int KW = $clog2(STEP + 1);
  localparam int RW = SHAMT_W + 1;
  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_step;
  logic [SHAMT_W-1:0] rem, rem_nxt;
  logic [1:0]         mode_q;
  logic [KW-1:0]      k;
  logic [RW-1:0]      rem_w;

  // Sub-step size: the final step shrinks to whatever amount remains.
  always_comb begin
    rem_w   = {1'b0, rem};
    k       = (rem_w < STEP_R) ? KW'(rem) : KW'(STEP);
    rem_nxt = rem - SHAMT_W'(k);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (acc),
    .k      (k),
    .mode   (mode_q),
    .result (acc_step)
  );

  // Next-state decode and handshake outputs.
  always_comb begin
    state_nxt    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (bus.in_valid) state_nxt = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        if (rem_w <= STEP_R) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        bus.busy  = 1'b0;
      end
    endcase
  end

  assign bus.data_out = acc;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Operand capture on accept, then one sub-step per SHIFT cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc    <= '0;
      rem    <= '0;
      mode_q <= MODE_SLL;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            acc    <= bus.data_in;
            rem    <= bus.shamt;
            mode_q <= bus.mode;
          end
        end
        ST_SHIFT: begin
          acc <= acc_step;
          rem <= rem_nxt;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench: two shifters (STEP=1 and STEP=4) against a single-cycle reference.
module tb_iter_shifter;
  import shifter_pkg::*;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          acc;
  } exp_t;

  logic clock;
  logic reset_n;
  logic rst_q = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   rdy_pct = 100;

  logic        iv[2];
  logic [31:0] din[2];
  logic [4:0]  sh[2];
  logic [1:0]  md[2];
  logic        ordy[2];
  logic        ir[2];
  logic        ov[2];
  logic        bz[2];
  logic [31:0] dout[2];

  exp_t        expq[2][$];
  logic        prev_ov[2];
  logic        prev_hs[2];
  logic [31:0] prev_dout[2];
  exp_t        mon_e;

  iter_shifter_if #(.WIDTH(32)) ifa ();
  iter_shifter_if #(.WIDTH(32)) ifb ();

  assign ifa.in_valid  = iv[0];
  assign ifa.data_in   = din[0];
  assign ifa.shamt     = sh[0];
  assign ifa.mode      = md[0];
  assign ifa.out_ready = ordy[0];
  assign ifb.in_valid  = iv[1];
  assign ifb.data_in   = din[1];
  assign ifb.shamt     = sh[1];
  assign ifb.mode      = md[1];
  assign ifb.out_ready = ordy[1];
  assign ir[0]   = ifa.in_ready;
  assign ov[0]   = ifa.out_valid;
  assign bz[0]   = ifa.busy;
  assign dout[0] = ifa.data_out;
  assign ir[1]   = ifb.in_ready;
  assign ov[1]   = ifb.out_valid;
  assign bz[1]   = ifb.busy;
  assign dout[1] = ifb.data_out;

  iter_shifter #(.WIDTH(32), .STEP(1)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
  iter_shifter #(.WIDTH(32), .STEP(4)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= reset_n;
  end

  function automatic int stp(int u);
    return (u == 0) ? 1 : 4;
  endfunction

  // Single-cycle reference shift.
  function automatic logic [31:0] ref_shift(logic [31:0] d, int s, logic [1:0] m);
    logic [31:0] r;
    case (m)
      MODE_SLL: r = d << s;
      MODE_SRL: r = d >> s;
      MODE_SRA: begin
        r = d >> s;
        if (d[31]) r = r | ~(32'hFFFF_FFFF >> s);
      end
      default:  r = (d >> s) | (d << (32 - s));
    endcase
    return r;
  endfunction

  task automatic chk(string nm, int u, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (t=%0t)", nm, u, act, want, $time);
    end
  endtask

  // Monitor: pops the scoreboard on each new result and checks the DONE-state contract.
  always @(negedge clock) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_q) begin
        prev_ov[u] = 1'b0;
        prev_hs[u] = 1'b0;
      end else begin
        if (prev_hs[u]) chk("release_idle", u, {30'd0, ov[u], ir[u]}, 32'd1);
        if (ov[u] && !prev_ov[u]) begin
          if (expq[u].size() == 0) begin
            chk("unexpected_out", u, 32'd0, 32'd1);
          end else begin
            mon_e = expq[u].pop_front();
            chk("data", u, dout[u], mon_e.data);
            chk("latency", u, 32'(cyc - mon_e.acc), 32'(mon_e.lat));
          end
        end else if (ov[u] && prev_ov[u] && !prev_hs[u]) begin
          chk("hold_stable", u, dout[u], prev_dout[u]);
          chk("no_accept_in_done", u, {31'd0, ir[u]}, 32'd0);
        end
        chk("busy", u, {31'd0, bz[u]}, {31'd0, ~ir[u]});
      end
      ordy[u]      = ($urandom_range(99) < rdy_pct);
      prev_ov[u]   = ov[u];
      prev_hs[u]   = ov[u] && ordy[u];
      prev_dout[u] = dout[u];
    end
  end

  task automatic issue(int u, logic [31:0] d, logic [4:0] s, logic [1:0] m);
    int t;
    exp_t e;
    iv[u] = 1'b1; din[u] = d; sh[u] = s; md[u] = m;
    t = 0;
    while (!ir[u] && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (!ir[u]) begin
      chk("accept_timeout", u, {31'd0, ir[u]}, 32'd1);
      iv[u] = 1'b0;
      return;
    end
    e.data = ref_shift(d, int'(s), m);
    e.lat  = (int'(s) + stp(u) - 1) / stp(u);
    e.acc  = cyc + 1;
    expq[u].push_back(e);
    @(negedge clock);
    iv[u] = 1'b0;
    din[u] = $urandom;
    sh[u]  = 5'($urandom_range(31));
  endtask

  task automatic drain(int u);
    int t;
    t = 0;
    while ((expq[u].size() != 0 || ov[u]) && t < 500) begin
      @(negedge clock);
      t++;
    end
    chk("drain", u, 32'(expq[u].size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      chk("rst_in_ready", u, {31'd0, ir[u]}, 32'd1);
      chk("rst_out_valid", u, {31'd0, ov[u]}, 32'd0);
      chk("rst_data_out", u, dout[u], 32'd0);
      chk("rst_busy", u, {31'd0, bz[u]}, 32'd0);
      expq[u].delete();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      iv[u] = 1'b0; din[u] = '0; sh[u] = '0; md[u] = '0; ordy[u] = 1'b0;
    end
    @(negedge clock);
    @(negedge clock);
    do_reset();

    rdy_pct = 100;
    issue(0, 32'h8000_0000, 5'd4,  MODE_SRA);
    issue(0, 32'h8000_0000, 5'd4,  MODE_SRL);
    issue(0, 32'h0000_0001, 5'd31, MODE_SLL);
    issue(0, 32'h0000_0001, 5'd1,  MODE_ROR);
    for (int m = 0; m < 4; m++) issue(0, 32'h1234_5678, 5'd0, 2'(m));
    issue(0, 32'h8000_0000, 5'd31, MODE_SRA);
    drain(0);

    rdy_pct = 0;
    fork
      begin
        repeat (6) @(negedge clock);
        rdy_pct = 100;
      end
      begin
        issue(0, 32'h1234_5678, 5'd0, MODE_SLL);
        issue(0, 32'hDEAD_BEEF, 5'd3, MODE_ROR);
      end
    join
    drain(0);

    issue(0, 32'h0000_0400, 5'd10, MODE_SRL);
    @(negedge clock);
    do_reset();
    issue(0, 32'h8000_0000, 5'd10, MODE_SRA);
    drain(0);

    rdy_pct = 70;
    for (int i = 0; i < 40; i++) begin
      issue(0, $urandom, 5'($urandom_range(31)), 2'($urandom_range(3)));
      if ($urandom_range(3) == 0) @(negedge clock);
    end
    drain(0);

    rdy_pct = 100;
    issue(1, 32'h8000_0000, 5'd31, MODE_SRA);
    issue(1, 32'hF000_0000, 5'd6,  MODE_SRL);
    issue(1, 32'h8765_4321, 5'd0,  MODE_ROR);
    drain(1);
    rdy_pct = 70;
    for (int i = 0; i < 40; i++) begin
      issue(1, $urandom, 5'($urandom_range(31)), 2'($urandom_range(3)));
      if ($urandom_range(3) == 0) @(negedge clock);
    end
    drain(1);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
